mole_scheduler: RTL and testbench

Game controller for the four-lane reaction game. It sequences lamp lanes with a pseudo-random spawn scheduler and times each raised lamp. It also detects button hits, maintains the saturating score, and runs the IDLE/PLAY/WIN game state machine. It sits between the board buttons/lamps and the VGA score display, driving `in_game` and `score` to it.

---
 rtl/mole_pkg.sv | 23 ++
 rtl/mole_lane.sv | 75 +++++++
 rtl/mole_scheduler.sv | 159 +++++++++++++++
 tb/tb_mole_scheduler.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/mole_pkg.sv
// Shared types, LFSR constants and score arithmetic for the mole_scheduler game controller.
package mole_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_WIN  = 2'd2
  } state_e;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Taps 16,14,13,11 of a right-shifting Fibonacci LFSR sit on bits 0,2,3,5.
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  function automatic int sat_add(input int base, input int inc, input int dec,
                                 input int max_val);
    int sum;
    sum = base + inc - dec;
    if (sum < 0) return 0;
    if (sum > max_val) return max_val;
    return sum;
  endfunction

endpackage

// File: rtl/mole_lane.sv
// One lamp/button lane: input synchronizer, press edge detect, up-timer, cooldown and lamp flop.
module mole_lane
  import mole_pkg::*;
#(
  parameter int UP_CYC       = 100000000,
  parameter int COOLDOWN_CYC = 250000000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_n,
  input  logic raise,
  input  logic clear,
  output logic lamp,
  output logic hit,
  output logic miss,
  output logic eligible
);

  localparam int UP_W = (UP_CYC > 1) ? $clog2(UP_CYC) : 1;
  localparam int CD_W = (COOLDOWN_CYC > 0) ? $clog2(COOLDOWN_CYC + 1) : 1;

  logic            sync1_q, sync2_q, prev_q;
  logic            lamp_q, lamp_d;
  logic [UP_W-1:0] up_q, up_d;
  logic [CD_W-1:0] cd_q, cd_d;
  logic            btn_evt, timeout;

  assign btn_evt  = prev_q & ~sync2_q;
  assign timeout  = lamp_q && (up_q == UP_W'(UP_CYC - 1));
  // A press landing on the timeout cycle wins: it is a hit, not a miss.
  assign hit      = ~clear & lamp_q & btn_evt;
  assign miss     = ~clear & timeout & ~btn_evt;
  assign eligible = ~lamp_q & (cd_q == '0);
  assign lamp     = lamp_q;

  always_comb begin
    // NOTE: every _d signal gets a default before any branch, so no path can infer a latch.
    lamp_d = lamp_q;
    up_d   = lamp_q ? up_q + 1'b1 : '0;
    cd_d   = (cd_q != '0) ? cd_q - 1'b1 : '0;
    if (clear) begin
      lamp_d = 1'b0;
      up_d   = '0;
      cd_d   = '0;
    end else if (hit || miss) begin
      lamp_d = 1'b0;
      up_d   = '0;
      cd_d   = CD_W'(COOLDOWN_CYC);
    end else if (raise) begin
      lamp_d = 1'b1;
      up_d   = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // Synchronizer resets to the released level so reset release never looks like a press.
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
      lamp_q  <= 1'b0;
      up_q    <= '0;
      cd_q    <= '0;
    end else begin
      sync1_q <= btn_n;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      lamp_q  <= lamp_d;
      up_q    <= up_d;
      cd_q    <= cd_d;
    end
  end

endmodule

// File: rtl/mole_scheduler.sv
// Four-lane reaction game controller: game FSM, LFSR spawn scheduler, lane array and saturating score.
module mole_scheduler
  import mole_pkg::*;
#(
  parameter int N_LANES      = 4,
  parameter int SCORE_W      = 8,
  parameter int UP_CYC       = 100000000,
  parameter int SPAWN_CYC    = 50000000,
  parameter int COOLDOWN_CYC = 250000000,
  parameter int MAX_UP       = 2,
  parameter int START_SCORE  = 3,
  parameter int WIN_SCORE    = 12
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_LANES-1:0] btn_n,
  input  logic               start_n,
  output logic [N_LANES-1:0] lamp,
  output logic               in_game,
  output logic [SCORE_W-1:0] score,
  output logic               hit_pulse,
  output logic               miss_pulse,
  output logic               win
);

  localparam int LANE_W    = (N_LANES > 1) ? $clog2(N_LANES) : 1;
  localparam int SP_W      = (SPAWN_CYC > 1) ? $clog2(SPAWN_CYC) : 1;
  localparam int SCORE_MAX = (2 ** SCORE_W) - 1;

  state_e              state_q, state_d;
  logic [15:0]         lfsr_q, lfsr_d;
  logic [SP_W-1:0]     spawn_q, spawn_d;
  logic                fire_q, fire_d;
  logic [SCORE_W-1:0]  score_q, score_d;
  logic                hit_q, hit_d, miss_q, miss_d;
  logic                start_s1_q, start_s2_q, start_prev_q;
  logic                start_evt;

  logic [N_LANES-1:0]  lane_lamp, lane_hit, lane_miss, lane_elig, lane_raise;
  logic                lane_clear;
  logic [LANE_W-1:0]   candidate;
  int                  n_hit, n_miss, n_up;

  assign start_evt = start_prev_q & ~start_s2_q;

  for (genvar g = 0; g < N_LANES; g++) begin : g_lane
    mole_lane #(
      .UP_CYC      (UP_CYC),
      .COOLDOWN_CYC(COOLDOWN_CYC)
    ) u_lane (
      .clk     (clk),
      .reset   (reset),
      .btn_n   (btn_n[g]),
      .raise   (lane_raise[g]),
      .clear   (lane_clear),
      .lamp    (lane_lamp[g]),
      .hit     (lane_hit[g]),
      .miss    (lane_miss[g]),
      .eligible(lane_elig[g])
    );
  end

  // Game FSM: lanes are held cleared outside PLAY, so a start always begins from a clean board.
  always_comb begin
    state_d    = state_q;
    lane_clear = 1'b1;
    in_game    = 1'b0;
    win        = 1'b0;
    lamp       = '0;
    case (state_q)
      ST_IDLE: begin
        if (start_evt) state_d = ST_PLAY;
      end
      ST_PLAY: begin
        lane_clear = 1'b0;
        in_game    = 1'b1;
        lamp       = lane_lamp;
        if (score_q >= SCORE_W'(WIN_SCORE)) state_d = ST_WIN;
      end
      ST_WIN: begin
        win  = 1'b1;
        lamp = '1;
        if (start_evt) state_d = ST_PLAY;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    n_hit  = $countones(lane_hit);
    n_miss = $countones(lane_miss);
    n_up   = $countones(lane_lamp);

    lfsr_d = {^(lfsr_q & LFSR_TAPS), lfsr_q[15:1]};

    // The wrap is registered into fire_q; the spawn decision is made in the cycle after the wrap.
    spawn_d = '0;
    fire_d  = 1'b0;
    if (state_q == ST_PLAY) begin
      if (spawn_q == SP_W'(SPAWN_CYC - 1)) begin
        spawn_d = '0;
        fire_d  = 1'b1;
      end else begin
        spawn_d = spawn_q + 1'b1;
      end
    end

    candidate  = lfsr_q[LANE_W-1:0];
    lane_raise = '0;
    for (int i = 0; i < N_LANES; i++) begin
      lane_raise[i] = fire_q && (state_q == ST_PLAY) && (candidate == LANE_W'(i)) &&
                      lane_elig[i] && (n_up < MAX_UP);
    end

    score_d = score_q;
    if (state_q == ST_PLAY) begin
      score_d = SCORE_W'(sat_add(int'(score_q), n_hit, n_miss, SCORE_MAX));
    end else if (start_evt) begin
      score_d = SCORE_W'(START_SCORE);
    end

    hit_d  = |lane_hit;
    miss_d = |lane_miss;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr_q       <= LFSR_SEED;
      spawn_q      <= '0;
      fire_q       <= 1'b0;
      score_q      <= '0;
      hit_q        <= 1'b0;
      miss_q       <= 1'b0;
      start_s1_q   <= 1'b1;
      start_s2_q   <= 1'b1;
      start_prev_q <= 1'b1;
    end else begin
      lfsr_q       <= lfsr_d;
      spawn_q      <= spawn_d;
      fire_q       <= fire_d;
      score_q      <= score_d;
      hit_q        <= hit_d;
      miss_q       <= miss_d;
      start_s1_q   <= start_n;
      start_s2_q   <= start_s1_q;
      start_prev_q <= start_s2_q;
    end
  end

  assign score      = score_q;
  assign hit_pulse  = hit_q;
  assign miss_pulse = miss_q;

endmodule

// File: tb/tb_mole_scheduler.sv
// Randomized bench for mole_scheduler against a timestamp-based game model.
module tb_mole_scheduler;

  localparam int N = 4, SW = 8, UP = 20, SPAWN = 8, CD = 10, MAXUP = 2;
  localparam int START = 3, WINS = 12, SMAX = 255;
  localparam int M_IDLE = 0, M_PLAY = 1, M_WIN = 2;
  localparam int MODE_NONE = 0, MODE_SMART = 1, MODE_RANDOM = 2, MODE_MIX = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  btn_n;
  logic          start_n;
  logic [N-1:0]  lamp;
  logic          in_game, hit_pulse, miss_pulse, win;
  logic [SW-1:0] score;

  always #5 clk = ~clk;

  mole_scheduler #(
    .N_LANES(N), .SCORE_W(SW), .UP_CYC(UP), .SPAWN_CYC(SPAWN), .COOLDOWN_CYC(CD),
    .MAX_UP(MAXUP), .START_SCORE(START), .WIN_SCORE(WINS)
  ) dut (
    .clk(clk), .reset(reset), .btn_n(btn_n), .start_n(start_n), .lamp(lamp),
    .in_game(in_game), .score(score), .hit_pulse(hit_pulse), .miss_pulse(miss_pulse), .win(win)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Game model: lanes tracked by rise time and the cycle from which they may rise again.
  int           m_mode, m_score, m_cyc, m_play_start;
  logic [N-1:0] m_up;
  int           m_rise[N];
  int           m_ready[N];
  logic [15:0]  m_lfsr;
  logic         m_hit, m_miss;
  logic [N-1:0] bh1, bh2, bh3;
  logic         sh1, sh2, sh3;
  int           low_left[N];
  int           start_left;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = M_IDLE; m_score = 0; m_cyc = 0; m_play_start = 0;
    m_up = '0; m_lfsr = 16'hACE1; m_hit = 1'b0; m_miss = 1'b0;
    bh1 = '1; bh2 = '1; bh3 = '1; sh1 = 1'b1; sh2 = 1'b1; sh3 = 1'b1;
    for (int i = 0; i < N; i++) begin
      m_rise[i] = 0; m_ready[i] = 0;
    end
  endtask

  task automatic model_step();
    logic [N-1:0] ev, drop;
    logic         sev, fb;
    int           hits, misses, upc, cand, since;
    ev  = bh3 & ~bh2;
    sev = sh3 & ~sh2;
    bh3 = bh2; bh2 = bh1; bh1 = btn_n;
    sh3 = sh2; sh2 = sh1; sh1 = start_n;
    hits = 0; misses = 0; drop = '0;
    if (m_mode == M_PLAY) begin
      upc = $countones(m_up);
      for (int i = 0; i < N; i++) begin
        if (m_up[i]) begin
          if (ev[i]) begin hits++; drop[i] = 1'b1; end
          else if (m_cyc - m_rise[i] == UP - 1) begin misses++; drop[i] = 1'b1; end
        end
      end
      cand  = -1;
      since = m_cyc - m_play_start;
      if (since >= SPAWN && since % SPAWN == 0) begin
        cand = int'(m_lfsr) % N;
        if (m_up[cand] || m_cyc < m_ready[cand] || upc >= MAXUP) cand = -1;
      end
      for (int i = 0; i < N; i++) begin
        if (drop[i]) begin m_up[i] = 1'b0; m_ready[i] = m_cyc + 1 + CD; end
      end
      if (cand >= 0) begin m_up[cand] = 1'b1; m_rise[cand] = m_cyc + 1; end
      if (m_score >= WINS) m_mode = M_WIN;
      m_score = m_score + hits - misses;
      if (m_score < 0) m_score = 0;
      if (m_score > SMAX) m_score = SMAX;
    end else if (sev) begin
      m_mode = M_PLAY; m_score = START; m_up = '0; m_play_start = m_cyc + 1;
      for (int i = 0; i < N; i++) m_ready[i] = 0;
    end
    m_hit  = hits > 0;
    m_miss = misses > 0;
    fb     = m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5];
    m_lfsr = {fb, m_lfsr[15:1]};
    m_cyc++;
  endtask

  task automatic compare();
    logic [N-1:0] exp_lamp;
    exp_lamp = (m_mode == M_WIN) ? '1 : ((m_mode == M_PLAY) ? m_up : '0);
    check("lamp", 32'(lamp), 32'(exp_lamp));
    check("score", 32'(score), 32'(m_score));
    check("in_game_win", 32'({in_game, win}), 32'({m_mode == M_PLAY, m_mode == M_WIN}));
    check("hit_miss_pulse", 32'({hit_pulse, miss_pulse}), 32'({m_hit, m_miss}));
    if (in_game) check("max_up", 32'($countones(lamp) <= MAXUP), 32'd1);
  endtask

  task automatic press(input int i);
    btn_n[i]    = 1'b0;
    low_left[i] = $urandom_range(1, 3);
  endtask

  task automatic drive(input int mode);
    logic [N-1:0] was_high;
    was_high = btn_n;
    for (int i = 0; i < N; i++) begin
      if (low_left[i] > 0) begin
        low_left[i]--;
        if (low_left[i] == 0) btn_n[i] = 1'b1;
      end
    end
    if (start_left > 0) begin
      start_left--;
      if (start_left == 0) start_n = 1'b1;
    end
    if ((mode == MODE_SMART || mode == MODE_MIX) && m_mode == M_PLAY &&
        $urandom_range(0, 2) == 0) begin
      for (int i = 0; i < N; i++) if (m_up[i] && was_high[i]) press(i);
    end
    if (mode == MODE_RANDOM || mode == MODE_MIX) begin
      for (int i = 0; i < N; i++)
        if (was_high[i] && btn_n[i] && $urandom_range(0, 11) == 0) press(i);
    end
  endtask

  task automatic cycle(input int mode);
    @(posedge clk);
    if (!reset) model_step();
    @(negedge clk);
    if (!reset) compare();
    drive(mode);
  endtask

  task automatic push_start();
    start_n    = 1'b0;
    start_left = 2;
  endtask

  task automatic release_inputs();
    btn_n = '1; start_n = 1'b1; start_left = 0;
    for (int i = 0; i < N; i++) low_left[i] = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_lamp"}, 32'(lamp), 32'd0);
    check({tag, "_score"}, 32'(score), 32'd0);
    check({tag, "_flags"}, 32'({in_game, win, hit_pulse, miss_pulse}), 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    release_inputs();
    model_reset();
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b0;

    repeat (5) cycle(MODE_NONE);
    push_start();
    // Unattended play: misses drain the score to 0 and further misses must not wrap it.
    repeat (150) cycle(MODE_NONE);

    for (int k = 0; k < 3000 && m_mode != M_WIN; k++) cycle(MODE_SMART);
    repeat (5) cycle(MODE_NONE);
    check("win_reached", 32'(win), 32'd1);

    push_start();
    repeat (400) cycle(MODE_MIX);

    if (m_mode != M_PLAY) begin
      push_start();
      repeat (10) cycle(MODE_NONE);
    end
    for (int k = 0; k < 200 && m_up == '0; k++) cycle(MODE_NONE);
    check("lamp_up_before_reset", 32'(lamp != '0), 32'd1);
    #2 reset = 1'b1;
    #1 check_reset_outputs("async_reset");
    model_reset();
    release_inputs();
    repeat (2) @(negedge clk);
    reset = 1'b0;

    repeat (3) cycle(MODE_NONE);
    push_start();
    repeat (250) cycle(MODE_SMART);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
